// File: rtl/bc_counter_pkg.sv
// Shared definitions for the bunch-crossing / orbit timing core:
// FSM state type, logic constants and the default orbit length.
package bc_counter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    WAIT_ORBIT = 3'b001,
    RUN        = 3'b010,
    LOCKED     = 3'b011,
    ERROR      = 3'b100
  } bc_fsm_t;

  localparam logic ZERO = 1'b0;
  localparam logic TRUE = 1'b1;

  localparam int unsigned LSB_CNT_MAX_DEFAULT = 3564;

  // States in which the BC counter free-runs
  function automatic logic is_counting(input logic [2:0] st);
    return (st == RUN) || (st == LOCKED) || (st == ERROR);
  endfunction

endpackage

// File: rtl/bc_sync_check.sv
// Orbit-pulse alignment checker: classifies each orbit pulse against the
// expected BC phase and counts consecutive aligned pulses towards lock.
module bc_sync_check
  import bc_counter_pkg::*;
#(
  parameter int unsigned LSB_W    = 12,
  parameter int unsigned EXP      = 0,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             orbit_i,
  input  logic [LSB_W-1:0] bc_cnt,
  output logic             aligned,
  output logic             misaligned,
  output logic             lock_reached
);

  logic [3:0] good_cnt;
  logic       phase_ok;

  assign phase_ok     = (bc_cnt == LSB_W'(EXP));
  assign aligned      = en && orbit_i && phase_ok;
  assign misaligned   = en && orbit_i && !phase_ok;
  // This aligned pulse brings (or keeps) the run length at LOCK_CNT
  assign lock_reached = aligned && (good_cnt >= 4'(LOCK_CNT - 1));

  // Consecutive-aligned-pulse counter, saturating at LOCK_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
    end else if (clr || misaligned) begin
      good_cnt <= '0;
    end else if (aligned && (good_cnt != 4'(LOCK_CNT))) begin
      good_cnt <= good_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/bc_orbit_counter.sv
// Bunch-crossing / orbit counter with orbit-sync FSM.
// Optional alignment checking, lock qualification and sticky error flag
// are enabled by defining BC_SYNC_CHECK_EN.
module bc_orbit_counter
  import bc_counter_pkg::*;
#(
  parameter int unsigned LSB_CNT_MAX = LSB_CNT_MAX_DEFAULT,
  parameter int unsigned MSB_W       = 32,
  parameter int unsigned BC_OFFSET   = 0,
  parameter int unsigned LOCK_CNT    = 3,
  localparam int unsigned LSB_W      = $clog2(LSB_CNT_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             orbit_i,
  input  logic             err_clr_i,
  output logic [LSB_W-1:0] bc_cnt_o,
  output logic [MSB_W-1:0] orbit_cnt_o,
  output logic             bc0_o,
  output logic             locked_o,
  output logic             sync_err_o,
  output logic [2:0]       state_o
);

  localparam int unsigned EXP = (BC_OFFSET + LSB_CNT_MAX - 1) % LSB_CNT_MAX;

  logic [2:0]       state_q, state_d;
  logic [LSB_W-1:0] bc_q, bc_d, bc_adv;
  logic [MSB_W-1:0] orbit_q, orbit_d, orbit_adv;
  logic             bc_wrap;
  logic             locked_d, bc0_d;
  logic             locked_q, bc0_q;

  assign bc_wrap   = (bc_q == LSB_W'(LSB_CNT_MAX - 1));
  assign bc_adv    = bc_wrap ? '0 : bc_q + LSB_W'(1);
  assign orbit_adv = bc_wrap ? orbit_q + MSB_W'(1) : orbit_q;

`ifdef BC_SYNC_CHECK_EN
  logic chk_en, aligned, misaligned, lock_reached;
  logic err_d, err_q;

  assign chk_en = is_counting(state_q) && !stop_i;

  bc_sync_check #(
    .LSB_W    (LSB_W),
    .EXP      (EXP),
    .LOCK_CNT (LOCK_CNT)
  ) u_sync_check (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (chk_en),
    .clr          (!chk_en),
    .orbit_i      (orbit_i),
    .bc_cnt       (bc_q),
    .aligned      (aligned),
    .misaligned   (misaligned),
    .lock_reached (lock_reached)
  );

  // Sticky error: a new error outranks a same-cycle clear; stop always clears
  always_comb begin
    err_d = err_q;
    if (stop_i)
      err_d = ZERO;
    else if (misaligned && ((state_q == LOCKED) || (state_q == ERROR)))
      err_d = TRUE;
    else if (err_clr_i)
      err_d = ZERO;
  end

  assign sync_err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign sync_err_o     = ZERO;
`endif

  // Next-state and counter update; stop outranks orbit, orbit outranks start
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    orbit_d = orbit_q;
    if (stop_i) begin
      state_d = IDLE;
      bc_d    = '0;
      orbit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bc_d    = '0;
          orbit_d = '0;
          if (start_i) state_d = WAIT_ORBIT;
        end
        WAIT_ORBIT: begin
          if (orbit_i) begin
            bc_d    = LSB_W'(BC_OFFSET);
            orbit_d = '0;
            state_d = RUN;
          end
        end
        RUN, LOCKED, ERROR: begin
`ifdef BC_SYNC_CHECK_EN
          if (misaligned) begin
            bc_d = LSB_W'(BC_OFFSET);
            if (state_q != RUN) state_d = ERROR;
          end else begin
            bc_d    = bc_adv;
            orbit_d = orbit_adv;
            if (aligned && lock_reached && (state_q != LOCKED))
              state_d = LOCKED;
          end
`else
          bc_d    = bc_adv;
          orbit_d = orbit_adv;
`endif
        end
        default: begin
          state_d = IDLE;
          bc_d    = '0;
          orbit_d = '0;
        end
      endcase
    end
  end

  // Flag outputs are computed from next-state values so they line up with
  // the registered counters they describe.
  always_comb begin
`ifdef BC_SYNC_CHECK_EN
    locked_d = (state_d == LOCKED);
`else
    locked_d = (state_d == RUN);
`endif
    bc0_d = is_counting(state_d) && (bc_d == '0);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bc_q     <= '0;
      orbit_q  <= '0;
      locked_q <= ZERO;
      bc0_q    <= ZERO;
`ifdef BC_SYNC_CHECK_EN
      err_q    <= ZERO;
`endif
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      orbit_q  <= orbit_d;
      locked_q <= locked_d;
      bc0_q    <= bc0_d;
`ifdef BC_SYNC_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bc_cnt_o    = bc_q;
  assign orbit_cnt_o = orbit_q;
  assign bc0_o       = bc0_q;
  assign locked_o    = locked_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bc_orbit_counter.sv
// Scoreboard bench for bc_orbit_counter: the driver updates a behavioural
// model at each falling edge and queues the expected post-edge outputs;
// a monitor pops one entry after every rising edge and compares.
module tb_bc_orbit_counter;

  localparam int M   = 16;
  localparam int MW  = 3;
  localparam int OFF = 3;
  localparam int LK  = 3;
  localparam int EXP = (OFF + M - 1) % M;

  localparam int S_IDLE = 0, S_WAIT = 1, S_RUN = 2, S_LOCK = 3, S_ERR = 4;

`ifdef BC_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, stop_i = 1'b0, orbit_i = 1'b0, err_clr_i = 1'b0;
  logic [3:0]    bc_cnt_o;
  logic [MW-1:0] orbit_cnt_o;
  logic          bc0_o, locked_o, sync_err_o;
  logic [2:0]    state_o;

  bc_orbit_counter #(
    .LSB_CNT_MAX (M),
    .MSB_W       (MW),
    .BC_OFFSET   (OFF),
    .LOCK_CNT    (LK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .orbit_i     (orbit_i),
    .err_clr_i   (err_clr_i),
    .bc_cnt_o    (bc_cnt_o),
    .orbit_cnt_o (orbit_cnt_o),
    .bc0_o       (bc0_o),
    .locked_o    (locked_o),
    .sync_err_o  (sync_err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    bc;
    logic [MW-1:0] orb;
    logic          bc0;
    logic          lk;
    logic          err;
    logic [2:0]    st;
  } obs_t;

  obs_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  int m_st = S_IDLE, m_bc = 0, m_orb = 0, m_good = 0;
  bit m_err = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    o.bc  = 4'(m_bc);
    o.orb = MW'(m_orb);
    o.bc0 = (m_st >= S_RUN) && (m_bc == 0);
    o.lk  = CHK ? (m_st == S_LOCK) : (m_st == S_RUN);
    o.err = m_err;
    o.st  = 3'(m_st);
    return o;
  endfunction

  function automatic void model_advance();
    if (m_bc == M - 1) begin
      m_bc  = 0;
      m_orb = (m_orb + 1) % (1 << MW);
    end else begin
      m_bc = m_bc + 1;
    end
  endfunction

  function automatic void model_update(bit s, bit p, bit o, bit c);
    bit new_err;
    new_err = 1'b0;
    if (!rst_n) begin
      m_st = S_IDLE; m_bc = 0; m_orb = 0; m_good = 0; m_err = 1'b0;
    end else if (p) begin
      m_st = S_IDLE; m_bc = 0; m_orb = 0; m_good = 0; m_err = 1'b0;
    end else begin
      if (m_st == S_IDLE) begin
        if (s) m_st = S_WAIT;
      end else if (m_st == S_WAIT) begin
        if (o) begin
          m_bc = OFF; m_orb = 0; m_good = 0; m_st = S_RUN;
        end
      end else begin
        if (o && CHK) begin
          if (m_bc == EXP) begin
            model_advance();
            if (m_good < LK) m_good = m_good + 1;
            if (m_good == LK) m_st = S_LOCK;
          end else begin
            m_bc   = OFF;
            m_good = 0;
            if (m_st != S_RUN) begin
              m_st    = S_ERR;
              new_err = 1'b1;
            end
          end
        end else begin
          model_advance();
        end
      end
      if (new_err) m_err = 1'b1;
      else if (c)  m_err = 1'b0;
    end
  endfunction

  task automatic step(input bit s, input bit p, input bit o, input bit c);
    @(negedge clk);
    start_i = s; stop_i = p; orbit_i = o; err_clr_i = c;
    model_update(s, p, o, c);
    q.push_back(model_obs());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Idle until the model's current BC equals b (bounded)
  task automatic run_to(input int b);
    for (int i = 0; i < 2 * M && m_bc != b; i++) step(0, 0, 0, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Assert reset between edges and check outputs clear immediately
  task automatic async_reset();
    obs_t a;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    a = {bc_cnt_o, orbit_cnt_o, bc0_o, locked_o, sync_err_o, state_o};
    tests++;
    if (a !== '0) begin
      fails++;
      $display("FAIL async_reset: got bc=%0d orb=%0d bc0=%0b lk=%0b err=%0b st=%0d, want all 0",
               a.bc, a.orb, a.bc0, a.lk, a.err, a.st);
    end
    model_update(0, 0, 0, 0);
    idle_steps(2);
    release_reset();
  endtask

  // Monitor: one scoreboard entry per rising edge
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {bc_cnt_o, orbit_cnt_o, bc0_o, locked_o, sync_err_o, state_o};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_check t=%0t: got bc=%0d orb=%0d bc0=%0b lk=%0b err=%0b st=%0d, want bc=%0d orb=%0d bc0=%0b lk=%0b err=%0b st=%0d",
                 $time, a.bc, a.orb, a.bc0, a.lk, a.err, a.st,
                 e.bc, e.orb, e.bc0, e.lk, e.err, e.st);
      end
    end
  end

  initial begin
    bit s, p, o, c;
    // Power-on reset
    idle_steps(3);
    release_reset();

    // Sync, then reset asynchronously mid-count at bc=9
    step(1, 0, 0, 0);
    idle_steps(2);
    step(0, 0, 1, 0);
    run_to(9);
    async_reset();

    // Sync and wrap, then lock on three aligned pulses
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle_steps(14);
    for (int k = 0; k < LK; k++) begin
      run_to(EXP);
      step(0, 0, 1, 0);
    end
    idle_steps(2);

    // Misaligned pulse while locked, then re-lock with error sticky
    run_to(7);
    step(0, 0, 1, 0);
    for (int k = 0; k < LK; k++) begin
      run_to(EXP);
      step(0, 0, 1, 0);
    end
    idle_steps(2);

    // Clear together with a misaligned pulse, then stop together with orbit
    run_to(5);
    step(0, 0, 1, 1);
    idle_steps(2);
    step(0, 1, 1, 0);
    idle_steps(2);

    // Randomised traffic, biased towards aligned pulses
    for (int i = 0; i < 2500; i++) begin
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 19) == 0);
      if (m_st >= S_RUN && m_bc == EXP) o = ($urandom_range(0, 9) != 0);
      else                              o = ($urandom_range(0, 39) == 0);
      step(s, p, o, c);
    end

    idle_steps(2);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bc_orbit_counter.md
# bc_orbit_counter

Parametrised bunch-crossing (BC) and orbit counter with an orbit-sync state machine. A BC counter wraps at `LSB_CNT_MAX` and increments an orbit counter. The block aligns to an external orbit pulse, qualifies lock over several consecutive aligned orbits, and optionally flags loss of alignment. It is the generalised timing core that shared-package FSM and constant definitions feed into, and the block is a TMR-triplication target.

## Interface
- `LSB_CNT_MAX`, default 3564: BCs per orbit; the BC counter runs 0..LSB_CNT_MAX-1. Legal range ≥ 2.
- `MSB_W`, default 32: orbit counter width.
- `BC_OFFSET`, default 0: BC value loaded on sync. Must be < LSB_CNT_MAX.
- `LOCK_CNT`, default 3: consecutive aligned orbit pulses required for lock. Legal range 1..15.
- Derived localparam `LSB_W = $clog2(LSB_CNT_MAX)`, which is 12 at the default.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: arm the counter; level-sampled in IDLE.
- `stop_i` in 1: return to IDLE.
- `orbit_i` in 1: orbit sync pulse, one cycle wide.
- `err_clr_i` in 1: clear sticky error.
- `bc_cnt_o` out LSB_W: current BC.
- `orbit_cnt_o` out MSB_W: current orbit.
- `bc0_o` out 1: high while `bc_cnt_o`==0 in a counting state.
- `locked_o` out 1: alignment qualified.
- `sync_err_o` out 1: sticky misalignment flag.
- `state_o` out 3: FSM encoding.

## Operation
- FSM states, 3-bit: IDLE=000, WAIT_ORBIT=001, RUN=010, LOCKED=011, ERROR=100. Encodings 101–111 are illegal and recover to IDLE on the next clock.
- **IDLE**
  - Counters are held at 0.
  - `start_i` moves the FSM to WAIT_ORBIT.
- **WAIT_ORBIT**
  - Counters are held.
  - On `orbit_i`: `bc_cnt`←BC_OFFSET, `orbit_cnt`←0, `good_cnt`←0, then go to RUN.
- **Counting states (RUN, LOCKED, ERROR)**
  - `bc_cnt` increments every cycle.
  - At LSB_CNT_MAX-1, `bc_cnt` wraps to 0 and `orbit_cnt` increments.
  - `orbit_cnt` wraps silently at 2^MSB_W-1 → 0.
- **Alignment check**
  - Expected phase `EXP` = (BC_OFFSET-1) mod LSB_CNT_MAX. With BC_OFFSET=0, EXP=LSB_CNT_MAX-1.
  - An `orbit_i` pulse is aligned if `bc_cnt`==EXP. Otherwise it is misaligned.
- **Aligned pulse**
  - Counters advance naturally.
  - `good_cnt` increments, saturating at LOCK_CNT.
  - In RUN or ERROR, when `good_cnt` reaches LOCK_CNT, go to LOCKED.
- **Misaligned pulse**
  - `bc_cnt`←BC_OFFSET; `orbit_cnt` is unchanged; `good_cnt`←0.
  - From RUN, stay in RUN.
  - From LOCKED or ERROR, go to ERROR and set `sync_err_o`.
- `locked_o` = 1 only in LOCKED.
- `sync_err_o`
  - Cleared by `err_clr_i` or `stop_i`.
  - If a new error and `err_clr_i` occur in the same cycle, the error wins and the flag stays 1.
- **Priority:** `rst_n` > `stop_i` > `orbit_i` > `start_i`.
  - `stop_i` in any state goes to IDLE and zeroes the counters on the next edge.

## Timing
- All outputs are registered.
- Reset values:
  - `bc_cnt_o`=0, `orbit_cnt_o`=0, `bc0_o`=0, `locked_o`=0, `sync_err_o`=0.
  - `state_o`=000.
- Reset assertion mid-count clears every register immediately, asynchronously.
- Sync latency: `orbit_i` sampled at edge N → `bc_cnt_o`=BC_OFFSET and `state_o`=RUN visible after edge N.
- Lock latency: `locked_o` rises the cycle after the LOCK_CNT-th aligned pulse.
- `sync_err_o` and the ERROR state appear the cycle after the misaligned pulse.
- `bc0_o` is derived from the next-state value, so it is coincident with `bc_cnt_o`==0.

## Configuration
- Macro: `BC_SYNC_CHECK_EN`.
- **Defined:** full alignment checking as described above.
- **Undefined:**
  - `orbit_i` is ignored once the FSM is in RUN, and RUN is the terminal counting state.
  - `locked_o` = 1 in RUN.
  - LOCKED and ERROR are unreachable.
  - `sync_err_o` is tied to 0 and `err_clr_i` is unused.

## Structure
- Package `bc_counter_pkg` holds:
  - `typedef enum logic [2:0] bc_fsm_t`, with the five states above;
  - constants ZERO=1'b0, TRUE=1'b1;
  - default LSB_CNT_MAX=3564.
- Sub-module `bc_sync_check`, instantiated only under `BC_SYNC_CHECK_EN`:
  - inputs: `orbit_i`, `bc_cnt`;
  - internal: `good_cnt`;
  - outputs: `aligned`, `misaligned`, `lock_reached`.
- The top level owns the FSM and both counters.

## Test plan
All scenarios use LSB_CNT_MAX=16 and BC_OFFSET=3 (EXP=2) unless stated, with macro defined where alignment is tested.
- **Reset:** `rst_n`=0 mid-count with `bc_cnt_o`=9 → all outputs 0 and `state_o`=000 immediately.
- **Sync and wrap:** `start_i`, then `orbit_i` → next cycle `bc_cnt_o`=3, `orbit_cnt_o`=0. 13 cycles later `bc_cnt_o`=0, `orbit_cnt_o`=1, `bc0_o`=1.
- **Lock:** three `orbit_i` pulses at `bc_cnt`=2 (LOCK_CNT=3) → `locked_o`=1 the cycle after the third pulse.
- **Misalignment:** in LOCKED, `orbit_i` at `bc_cnt`=7 → next cycle `bc_cnt_o`=3, `state_o`=100, `sync_err_o`=1, `locked_o`=0. Three aligned pulses → LOCKED, with `sync_err_o` still 1.
- **Clear vs. error and stop:** `err_clr_i` together with a misaligned pulse → `sync_err_o` stays 1. `stop_i` together with `orbit_i` → IDLE, counters 0, `sync_err_o`=0.
- **Macro undefined, plus orbit wrap:** misaligned `orbit_i` in RUN → no reload, `locked_o` stays 1. Separately, MSB_W=2 → `orbit_cnt_o` goes 3→0 at wrap.
